// File: rtl/dsig_pkg.sv
// Shared types and helpers for the delta-sigma DAC stage.
// Holds the default sample width, the sample type and the divider/offset helpers.
package dsig_pkg;

   localparam int unsigned DATA_BITS = 24;

   typedef logic signed [DATA_BITS-1:0] sample_t;

   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned sample_rate);
      return clk_freq / sample_rate;
   endfunction

   // Two's complement to offset binary: flip the sign bit.
   function automatic logic [DATA_BITS-1:0] to_offset(input sample_t s);
      return {~s[DATA_BITS-1], s[DATA_BITS-2:0]};
   endfunction

endpackage

// File: rtl/dsig_dac_if.sv
// Sample handshake between the UART receive path and the DAC stage.
interface dsig_dac_if
   import dsig_pkg::*;
#(
   parameter int unsigned DATA_BITS = dsig_pkg::DATA_BITS
);

   logic [DATA_BITS-1:0] data_i;
   logic                 valid_i;
   logic                 ready_o;

   modport master (output data_i, output valid_i, input ready_o);
   modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/dsig_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to separate full from empty.
module dsig_fifo
   import dsig_pkg::*;
#(
   parameter int unsigned DATA_BITS = dsig_pkg::DATA_BITS,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic [DATA_BITS-1:0] i_din,
   output logic [DATA_BITS-1:0] o_dout,
   output logic                 o_full,
   output logic                 o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_BITS-1:0] r_mem [DEPTH];
   logic [AW:0]          r_wp;
   logic [AW:0]          r_rp;
   logic                 w_wr;
   logic                 w_rd;

   assign o_empty = (r_wp == r_rp);
   assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign o_dout  = r_mem[r_rp[AW-1:0]];
   assign w_wr    = i_push && !o_full;
   assign w_rd    = i_pop && !o_empty;

   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wp[AW-1:0]] <= i_din;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_rd) r_rp <= r_rp + 1'b1;
      end
   end

endmodule

// File: rtl/dsig_dac.sv
// First-order delta-sigma DAC: buffers samples, pops one per sample tick,
// and modulates the current sample into a 1-bit pulse-density stream.
module dsig_dac
   import dsig_pkg::*;
#(
   parameter int unsigned DATA_BITS   = dsig_pkg::DATA_BITS,
   parameter int unsigned CLK_FREQ    = 50000000,
   parameter int unsigned SAMPLE_RATE = 48000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   dsig_dac_if.slave  bus,
   input  logic       clr_underrun_i,
   output logic       dsm_o,
   output logic       underrun_o
);

   localparam int unsigned DIV   = calc_div(CLK_FREQ, SAMPLE_RATE);
   localparam int unsigned DIV_W = $clog2(DIV);

   logic [DIV_W-1:0]     r_div;
   logic [DATA_BITS-1:0] r_cur;
   logic [DATA_BITS-1:0] r_acc;
   logic                 r_armed;
   logic                 r_dsm;
   logic                 r_underrun;

   logic                 w_tick;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_head;
   logic [DATA_BITS-1:0] w_u;
   logic [DATA_BITS:0]   w_sum;

   assign w_tick      = (r_div == DIV_W'(DIV - 1));
   assign w_push      = bus.valid_i && !w_full;
   assign w_pop       = w_tick && !w_empty;
   assign bus.ready_o = !w_full;
   assign w_u         = {~r_cur[DATA_BITS-1], r_cur[DATA_BITS-2:0]};
   assign w_sum       = {1'b0, r_acc} + {1'b0, w_u};
   assign dsm_o       = r_dsm;
   assign underrun_o  = r_underrun;

   dsig_fifo #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (bus.data_i),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_div      <= '0;
         r_cur      <= '0;
         r_acc      <= '0;
         r_armed    <= 1'b0;
         r_dsm      <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (w_pop) r_cur <= w_head;
         {r_dsm, r_acc} <= w_sum;
         if (w_push) r_armed <= 1'b1;
         // A fresh underrun outranks a same-cycle clear.
         if (w_tick && w_empty && r_armed) r_underrun <= 1'b1;
         else if (clr_underrun_i)          r_underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dsig_dac.sv
// Directed and randomized bench for dsig_dac against a queue-based reference model.
module tb_dsig_dac;
   import dsig_pkg::*;

   localparam int unsigned DW    = 24;
   localparam int unsigned CF    = 1000;
   localparam int unsigned SR    = 50;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DIV   = CF / SR;
   localparam longint unsigned FULLSCALE = 64'd1 << DW;
   localparam longint unsigned HALF      = 64'd1 << (DW - 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic dsm;
   logic und;

   dsig_dac_if #(.DATA_BITS(DW)) bus ();

   dsig_dac #(
      .DATA_BITS   (DW),
      .CLK_FREQ    (CF),
      .SAMPLE_RATE (SR),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .bus            (bus),
      .clr_underrun_i (clr),
      .dsm_o          (dsm),
      .underrun_o     (und)
   );

   always #5 clk = ~clk;

   longint unsigned m_q[$];
   longint unsigned m_cur, m_acc;
   int unsigned     m_cnt;
   bit              m_dsm, m_und, m_armed;
   int              compared   = 0;
   int              mismatched = 0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behaviour at one clock edge, from the spec's rules.
   task automatic model_step(input bit v, input longint unsigned d, input bit c, input bit r);
      bit tick, accept, set_und;
      int sz;
      longint unsigned sum;
      if (r) begin
         m_q.delete();
         m_cur = 0; m_acc = 0; m_cnt = 0;
         m_dsm = 0; m_und = 0; m_armed = 0;
      end else begin
         tick    = (m_cnt == DIV - 1);
         sz      = m_q.size();
         accept  = v && (sz < DEPTH);
         set_und = 0;
         sum     = m_acc + ((m_cur + HALF) % FULLSCALE);
         m_dsm   = (sum >= FULLSCALE);
         m_acc   = sum % FULLSCALE;
         if (tick) begin
            if (sz > 0) m_cur = m_q.pop_front();
            else if (m_armed) set_und = 1;
         end
         m_und = set_und ? 1'b1 : (c ? 1'b0 : m_und);
         if (accept) m_q.push_back(d % FULLSCALE);
         if (accept) m_armed = 1;
         m_cnt = tick ? 0 : m_cnt + 1;
      end
   endtask

   task automatic cyc(input bit v, input longint unsigned d, input bit c, input bit r);
      logic [DW-1:0] w;
      w           = d[DW-1:0];
      bus.valid_i = v;
      bus.data_i  = w;
      clr         = c;
      rst         = r;
      @(posedge clk);
      model_step(v, d, c, r);
      #1;
      chk("ready_o", bus.ready_o, (m_q.size() < DEPTH));
      chk("dsm_o", dsm, m_dsm);
      chk("underrun_o", und, m_und);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   // Hold a word valid until accepted or until the cycle budget runs out.
   task automatic push_hold(input longint unsigned d, input string tag);
      bit done;
      done = 0;
      for (int i = 0; i < 3 * DIV && !done; i++) begin
         done = bus.ready_o;
         cyc(1, d, 0, 0);
      end
      chk(tag, done, 1'b1);
   endtask

   initial begin
      longint unsigned init_words[4];
      int ones;
      init_words[0] = 64'h7FFFFF;
      init_words[1] = 64'h800000;
      init_words[2] = 64'h000000;
      init_words[3] = 64'h400000;
      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      model_step(0, 0, 0, 1);

      // Reset, then idle: midscale alternation and no underrun before arming.
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("reset_ready", bus.ready_o, 1'b1);
      chk("reset_dsm", dsm, 1'b0);
      chk("reset_underrun", und, 1'b0);
      idle(10 * DIV + 3);

      // Align just after a tick, then fill the FIFO back-to-back.
      for (int i = 0; i < DIV && m_cnt != 0; i++) cyc(0, 0, 0, 0);
      foreach (init_words[k]) cyc(1, init_words[k], 0, 0);
      chk("full_ready_low", bus.ready_o, 1'b0);
      push_hold(64'h123456, "fifth_word_accepted");
      idle(7 * DIV);

      // Quarter scale stream.
      for (int k = 0; k < 8; k++) push_hold(64'hC00000, "quarter_push");
      ones = 0;
      for (int i = 0; i < 4 * DIV; i++) begin
         cyc(0, 0, 0, 0);
         ones += int'(dsm);
      end
      chk("quarter_density", (ones >= DIV - 1) && (ones <= DIV + 1), 1'b1);
      idle(5 * DIV);

      // Randomized traffic including clears.
      for (int i = 0; i < 4000; i++)
         cyc(($urandom_range(0, 15) == 0), {32'h0, $urandom}, ($urandom_range(0, 31) == 0), 0);

      // Underrun: one sample, then starve; clear coincident with a tick keeps it set.
      cyc(0, 0, 0, 1);
      cyc(1, {32'h0, $urandom}, 0, 0);
      idle(2 * DIV + 2);
      chk("underrun_set", und, 1'b1);
      for (int i = 0; i < DIV && m_cnt != DIV - 1; i++) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      chk("clear_on_tick_held", und, 1'b1);
      cyc(0, 0, 1, 0);
      chk("clear_alone", und, 1'b0);
      idle(3);

      // Mid-stream reset with samples queued.
      for (int i = 0; i < DIV && m_cnt != 0; i++) cyc(0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(1, {32'h0, $urandom}, 0, 0);
      cyc(0, 0, 0, 1);
      chk("midrst_ready", bus.ready_o, 1'b1);
      chk("midrst_dsm", dsm, 1'b0);
      chk("midrst_underrun", und, 1'b0);
      idle(3 * DIV);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
